// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between ICache reads and DCache
// reads/writes. One transaction at a time: grant, issue with stall
// handshake, optional read wait with timeout, one-cycle done pulse.
// Also keeps saturating grant counters per requester.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   i_req/i_addr             ICache read request (held until i_done)
//   i_done/i_rdata           ICache completion pulse and read data
//   d_req/d_wr/d_addr/d_wdata DCache request (held until d_done)
//   d_done/d_rdata           DCache completion pulse and read data
//   err                      read timeout flag, pulses with done
//   busy                     high whenever a transaction is in flight
//   mem_req/mem_wr/mem_addr/mem_wdata  memory request side
//   mem_stall/mem_rvalid/mem_rdata     memory response side
//   i_grant_cnt/d_grant_cnt  saturating grant counters
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  // Timer only needs to count up to TIMEOUT-1 before the abort decision.
  localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q;
  logic             owner_d_q;   // 1 = DCache owns the current transaction
  logic             last_d_q;    // 1 = DCache was granted last
  logic             wr_q;
  logic [TMR_W-1:0] timer_q;
  logic             gnt_d;

  // On a tie, grant the side that was not granted last.
  assign gnt_d = d_req & (~i_req | ~last_d_q);

  // Single-process FSM; every output is a register updated on transitions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_d_q   <= 1'b0;
      last_d_q    <= 1'b1;
      wr_q        <= 1'b0;
      timer_q     <= '0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      err         <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_req || d_req) begin
            owner_d_q <= gnt_d;
            wr_q      <= gnt_d & d_wr;
            mem_addr  <= gnt_d ? d_addr : i_addr;
            mem_wdata <= gnt_d ? d_wdata : '0;
            mem_req   <= 1'b1;
            mem_wr    <= gnt_d & d_wr;
            busy      <= 1'b1;
            state_q   <= S_ISSUE;
            if (gnt_d) begin
              if (d_grant_cnt != '1) d_grant_cnt <= d_grant_cnt + CNT_W'(1);
            end else begin
              if (i_grant_cnt != '1) i_grant_cnt <= i_grant_cnt + CNT_W'(1);
            end
          end
        end
        S_ISSUE: begin
          if (!mem_stall) begin
            mem_req <= 1'b0;
            mem_wr  <= 1'b0;
            timer_q <= '0;
            if (wr_q) begin
              i_done  <= ~owner_d_q;
              d_done  <= owner_d_q;
              state_q <= S_DONE;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Data arriving on the final timer cycle still wins over the abort.
          if (mem_rvalid) begin
            if (owner_d_q) d_rdata <= mem_rdata;
            else           i_rdata <= mem_rdata;
            i_done  <= ~owner_d_q;
            d_done  <= owner_d_q;
            state_q <= S_DONE;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            i_done  <= ~owner_d_q;
            d_done  <= owner_d_q;
            err     <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_DONE: begin
          last_d_q <= owner_d_q;
          busy     <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter. A transaction-level model predicts the
// winner, stall/wait/timeout timing, done/err pulses, read data and the
// saturating grant counters; a timed memory driver supplies stalls, rvalid
// and ignored stray rvalid pulses. Includes async reset mid-transaction.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned CNT_W   = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam int          NEVER   = 1000;

  logic              clk, rst;
  logic              i_req, i_done;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req, d_wr, d_done;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              err, busy, mem_req, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_stall, mem_rvalid;
  logic [CNT_W-1:0]  i_grant_cnt, d_grant_cnt;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .err(err), .busy(busy),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit                last_d;
  int                cnt_i, cnt_d;
  logic [DATA_W-1:0] exp_ir, exp_dr;
  bit                after_reset;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    last_d = 1'b1;
    cnt_i  = 0;
    cnt_d  = 0;
    exp_ir = '0;
    exp_dr = '0;
  endtask

  // Runs one transaction; entered at the negedge of the IDLE cycle with
  // requests already driven. Cycle c is counted from that IDLE cycle (c=0).
  task automatic run_txn(input int force_r);
    bit                gd, wr, rd, e_err;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd, rdat;
    int                s, r, w, dc;
    gd = d_req && (!i_req || !last_d);
    wr = gd && d_wr;
    rd = !wr;
    a  = gd ? d_addr : i_addr;
    wd = d_wdata;
    s  = $urandom_range(0, 3);
    if (force_r > 0) r = force_r;
    else begin
      case ($urandom_range(0, 5))
        0, 1, 2: r = $urandom_range(1, 4);
        3, 4:    r = TIMEOUT - 1 + $urandom_range(0, 2);
        default: r = NEVER;
      endcase
    end
    w     = (r < TIMEOUT) ? r : TIMEOUT;
    dc    = rd ? 2 + s + w : 2 + s;
    e_err = rd && (r > TIMEOUT);
    rdat  = DATA_W'($urandom);
    if (gd) cnt_d = (cnt_d < CNT_MAX) ? cnt_d + 1 : cnt_d;
    else    cnt_i = (cnt_i < CNT_MAX) ? cnt_i + 1 : cnt_i;

    for (int c = 0; c <= dc; c++) begin
      if (c > 0) begin
        @(negedge clk);
        check("busy", 32'(busy), 32'(1));
        check("mem_req", 32'(mem_req), 32'(c <= 1 + s));
        if (c <= 1 + s) begin
          check("mem_wr", 32'(mem_wr), 32'(wr));
          check("mem_addr", 32'(mem_addr), 32'(a));
          if (wr) check("mem_wdata", 32'(mem_wdata), 32'(wd));
        end
        check("done_i_d_err", 32'({i_done, d_done, err}),
              32'({c == dc && !gd, c == dc && gd, c == dc && e_err}));
        if (c == dc) begin
          if (rd && !e_err) begin
            if (gd) exp_dr = rdat;
            else    exp_ir = rdat;
          end
          check("i_rdata", 32'(i_rdata), 32'(exp_ir));
          check("d_rdata", 32'(d_rdata), 32'(exp_dr));
          check("cnts", 32'({i_grant_cnt, d_grant_cnt}), 32'({CNT_W'(cnt_i), CNT_W'(cnt_d)}));
        end
        // The owner's bus may change during service without effect.
        if (gd) begin
          d_addr  = ADDR_W'($urandom);
          d_wdata = DATA_W'($urandom);
        end else begin
          i_addr = ADDR_W'($urandom);
        end
      end
      mem_stall = (c >= 1 && c <= s);
      if (rd && c == 1 + s + r) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdat;
      end else if ((c <= 1 + s || !rd || c == dc) && $urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1;              // stray data outside WAIT
        mem_rdata  = DATA_W'($urandom);
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = DATA_W'($urandom);
      end
      if (c == dc) begin
        if (gd) d_req = 1'b0;
        else    i_req = 1'b0;
      end
    end
    last_d = gd;
  endtask

  task automatic raise_i();
    i_req  = 1'b1;
    i_addr = ADDR_W'($urandom);
  endtask

  task automatic raise_d();
    d_req   = 1'b1;
    d_wr    = 1'($urandom_range(0, 1));
    d_addr  = ADDR_W'($urandom);
    d_wdata = DATA_W'($urandom);
  endtask

  // Async reset while a read is in ISSUE (stalled) or in WAIT.
  task automatic reset_test(input bit in_wait);
    @(negedge clk);
    i_req      = 1'b1;
    i_addr     = ADDR_W'($urandom);
    d_req      = 1'b0;
    mem_rvalid = 1'b0;
    mem_stall  = 1'b0;
    @(negedge clk);
    check("rst_pre_req", 32'(mem_req), 32'(1));
    mem_stall = !in_wait;
    if (in_wait) begin
      @(negedge clk);
      check("rst_pre_wait", 32'({busy, mem_req}), 32'(2'b10));
    end
    #2 rst = 1'b0;
    #1 check("rst_async", 32'({busy, mem_req}), 32'(0));
    i_req     = 1'b0;
    mem_stall = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_pulses", 32'({i_done, d_done, err, mem_wr}), 32'(0));
    check("rst_rdata", 32'({i_rdata, d_rdata}), 32'(0));
    check("rst_cnts", 32'({i_grant_cnt, d_grant_cnt}), 32'(0));
    rst        = 1'b1;
    mem_rvalid = 1'b1;                  // late data after abort
    mem_rdata  = 16'hDEAD;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst_late_rvalid", 32'({busy, i_rdata}), 32'(0));
    after_reset = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    i_req      = 1'b0;
    i_addr     = '0;
    d_req      = 1'b0;
    d_wr       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    mem_stall  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_ctrl", 32'({busy, mem_req, mem_wr, i_done, d_done, err}), 32'(0));
    check("reset_mem_addr", 32'(mem_addr), 32'(0));
    check("reset_mem_wdata", 32'(mem_wdata), 32'(0));
    check("reset_rdata", 32'({i_rdata, d_rdata}), 32'(0));
    check("reset_cnts", 32'({i_grant_cnt, d_grant_cnt}), 32'(0));
    rst = 1'b1;
    after_reset = 1'b1;

    for (int t = 0; t < 160; t++) begin
      if (t == 50 || t == 110) reset_test(t == 110);
      @(negedge clk);
      check("idle_busy_req", 32'({busy, mem_req}), 32'(0));
      check("idle_cnts", 32'({i_grant_cnt, d_grant_cnt}), 32'({CNT_W'(cnt_i), CNT_W'(cnt_d)}));
      if (after_reset) begin
        // First tie after reset must go to ICache, then DCache.
        raise_i();
        raise_d();
        after_reset = 1'b0;
      end else begin
        if (!i_req && $urandom_range(0, 1) == 1) raise_i();
        if (!d_req && $urandom_range(0, 1) == 1) raise_d();
        if (!i_req && !d_req) begin
          if ($urandom_range(0, 1) == 1) raise_i();
          else raise_d();
        end
      end
      run_txn((t % 7 == 3) ? NEVER : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
